// File: rtl/registro_notas_desplazables.sv
// rtl/registro_notas_desplazables.sv - multi-slot falling-note register with frame-tick scrolling
//
// Holds up to NUM_SLOTS falling notes (note number + Y position). New notes
// go into the lowest free slot; every tickFrame moves active notes down by
// PASO_Y. A note that passes Y_LIMITE frees its slot.
//
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   cargaNota, numeroNotaIn   load request and the note number to load
//   listoCarga                at least one slot is free
//   tickFrame                 one-cycle frame pulse, advances active notes
//   indiceLectura             slot index for the read port
//   numeroNotaOut,
//   posicionNotaYOut,
//   slotActivoOut             registered contents of the read slot
//   slotsActivos              per-slot active flags
//   cuentaActivos             number of active slots
//   notaPerdida               pulse: a load arrived while every slot was busy
module registro_notas_desplazables #(
    parameter int NUM_BITS_NOTA = 7,
    parameter int NUM_BITS_Y    = 10,
    parameter int NUM_SLOTS     = 8,
    parameter int Y_INICIAL     = 0,
    parameter int Y_LIMITE      = 479,
    parameter int PASO_Y        = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cargaNota,
    input  logic [NUM_BITS_NOTA-1:0]         numeroNotaIn,
    output logic                             listoCarga,
    input  logic                             tickFrame,
    input  logic [$clog2(NUM_SLOTS)-1:0]     indiceLectura,
    output logic [NUM_BITS_NOTA-1:0]         numeroNotaOut,
    output logic [NUM_BITS_Y-1:0]            posicionNotaYOut,
    output logic                             slotActivoOut,
    output logic [NUM_SLOTS-1:0]             slotsActivos,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   cuentaActivos,
    output logic                             notaPerdida
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [NUM_BITS_Y-1:0] Y_INI = NUM_BITS_Y'(Y_INICIAL);
    localparam logic [NUM_BITS_Y:0]   Y_LIM = (NUM_BITS_Y + 1)'(Y_LIMITE);
    localparam logic [NUM_BITS_Y:0]   PASO  = (NUM_BITS_Y + 1)'(PASO_Y);

    // Slot state
    logic [NUM_SLOTS-1:0]     activo;
    logic [NUM_BITS_NOTA-1:0] nota [NUM_SLOTS];
    logic [NUM_BITS_Y-1:0]    pos_y [NUM_SLOTS];
    logic [CNT_W-1:0]         cuenta;

    // Next-state
    logic [NUM_SLOTS-1:0]     activo_sig;
    logic [NUM_BITS_NOTA-1:0] nota_sig [NUM_SLOTS];
    logic [NUM_BITS_Y-1:0]    pos_y_sig [NUM_SLOTS];
    logic [CNT_W-1:0]         cuenta_sig;
    logic [NUM_BITS_Y:0]      suma [NUM_SLOTS];
    logic                     hay_libre;
    logic [IDX_W-1:0]         libre_idx;
    logic                     lectura_valida;

    assign listoCarga    = ~&activo;
    assign slotsActivos  = activo;
    assign cuentaActivos = cuenta;

    always_comb begin
        activo_sig = activo;
        hay_libre  = 1'b0;
        libre_idx  = '0;
        cuenta_sig = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            nota_sig[i]  = nota[i];
            pos_y_sig[i] = pos_y[i];
            suma[i]      = {1'b0, pos_y[i]} + PASO;
        end

        // Scanning downward leaves the lowest free index selected; this uses
        // the pre-tick flags so a slot retired this cycle is not reused yet.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!activo[i]) begin
                hay_libre = 1'b1;
                libre_idx = IDX_W'(i);
            end
        end

        // The sum is one bit wider than Y so passing the limit cannot wrap.
        if (tickFrame) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (activo[i]) begin
                    if (suma[i] > Y_LIM) begin
                        activo_sig[i] = 1'b0;
                        pos_y_sig[i]  = Y_INI;
                    end else begin
                        pos_y_sig[i]  = suma[i][NUM_BITS_Y-1:0];
                    end
                end
            end
        end

        // The target slot was inactive, so the tick never touched it and the
        // new note starts at Y_INICIAL regardless of tickFrame.
        if (cargaNota && hay_libre) begin
            activo_sig[libre_idx] = 1'b1;
            nota_sig[libre_idx]   = numeroNotaIn;
            pos_y_sig[libre_idx]  = Y_INI;
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            cuenta_sig = cuenta_sig + CNT_W'(activo_sig[i]);
        end
    end

    assign lectura_valida = (int'(indiceLectura) < NUM_SLOTS);

    always_ff @(posedge clock) begin
        if (reset) begin
            activo           <= '0;
            cuenta           <= '0;
            notaPerdida      <= 1'b0;
            numeroNotaOut    <= '0;
            posicionNotaYOut <= '0;
            slotActivoOut    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                nota[i]  <= '0;
                pos_y[i] <= Y_INI;
            end
        end else begin
            activo      <= activo_sig;
            cuenta      <= cuenta_sig;
            notaPerdida <= cargaNota & ~hay_libre;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                nota[i]  <= nota_sig[i];
                pos_y[i] <= pos_y_sig[i];
            end
            // Read port captures the slot as it stood before this edge.
            if (lectura_valida) begin
                numeroNotaOut    <= nota[indiceLectura];
                posicionNotaYOut <= pos_y[indiceLectura];
                slotActivoOut    <= activo[indiceLectura];
            end else begin
                numeroNotaOut    <= '0;
                posicionNotaYOut <= '0;
                slotActivoOut    <= 1'b0;
            end
        end
    end

endmodule
